// File: rtl/q_pkg.sv
// Shared sizing helper and reset levels for the relay pipe.
package q_pkg;

    localparam logic Q_V_RST = 1'b0;
    localparam logic Q_B_RST = 1'b1;

    // Bits needed to hold values 0..n-1 (n >= 2).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/q_relay_stage.sv
// One relay stage: SLOTS-deep circular buffer with registered valid/back-pressure.
module q_relay_stage
    import q_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLOTS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] src_d,
    input  logic             src_v,
    output logic             src_b,
    output logic [WIDTH-1:0] snk_d,
    output logic             snk_v,
    input  logic             snk_b,
    output logic             empty,
    output logic             err
);

    localparam int PW = clog2(SLOTS);
    localparam int OW = clog2(SLOTS + 1);
    localparam logic [OW-1:0] FULL   = OW'(SLOTS);
    localparam logic [OW-1:0] ALMOST = OW'(SLOTS - 1);
    localparam logic [PW-1:0] LAST   = PW'(SLOTS - 1);

    logic [WIDTH-1:0] mem [SLOTS];
    logic [OW-1:0]    occ;
    logic [OW-1:0]    occ_next;
    logic [PW-1:0]    rd;
    logic [PW-1:0]    wr;
    logic             ib_q;
    logic             ob_q;
    logic             err_q;
    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        pop      = (occ != '0) && !ob_q;
        drop     = src_v && (occ == FULL) && !pop;
        push     = src_v && !drop;
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 1'b1;
        end else if (pop && !push) begin
            occ_next = occ - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ   <= '0;
            rd    <= '0;
            wr    <= '0;
            err_q <= 1'b0;
            ib_q  <= Q_B_RST;
            ob_q  <= Q_B_RST;
        end else begin
            ob_q <= snk_b;
            occ  <= occ_next;
            ib_q <= (occ_next >= ALMOST);
            if (push) begin
                wr <= (wr == LAST) ? '0 : wr + 1'b1;
            end
            if (pop) begin
                rd <= (rd == LAST) ? '0 : rd + 1'b1;
            end
            if (drop) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset; contents only matter while occupied.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr] <= src_d;
        end
    end

    assign snk_v = (occ == '0) ? Q_V_RST : !ob_q;
    assign snk_d = mem[rd];
    assign src_b = ib_q;
    assign empty = (occ == '0);
    assign err   = err_q;

endmodule

// File: rtl/q_relay_pipe.sv
// Pipelined d/v/b stream link made of DEPTH chained relay stages.
module q_relay_pipe
    import q_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16,
    parameter int SLOTS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_v,
    output logic             i_b,
    output logic [WIDTH-1:0] o_d,
    output logic             o_v,
    input  logic             o_b,
    output logic             o_empty,
    output logic             o_err
);

    logic [DEPTH:0][WIDTH-1:0] d;
    logic [DEPTH:0]            v;
    logic [DEPTH:0]            b;
    logic [DEPTH-1:0]          empty;
    logic [DEPTH-1:0]          err;

    assign d[0]     = i_d;
    assign v[0]     = i_v;
    assign i_b      = b[0];
    assign o_d      = d[DEPTH];
    assign o_v      = v[DEPTH];
    assign b[DEPTH] = o_b;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        q_relay_stage #(
            .WIDTH(WIDTH),
            .SLOTS(SLOTS)
        ) u_stage (
            .clock(clock),
            .reset(reset),
            .src_d(d[k]),
            .src_v(v[k]),
            .src_b(b[k]),
            .snk_d(d[k+1]),
            .snk_v(v[k+1]),
            .snk_b(b[k+1]),
            .empty(empty[k]),
            .err  (err[k])
        );
    end

    assign o_empty = &empty;
    assign o_err   = |err;

endmodule

// File: tb/tb_q_relay_pipe.sv
// Directed bench for q_relay_pipe: a DEPTH=4 link and a DEPTH=1/WIDTH=1 corner instance.
module tb_q_relay_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a;
    logic [15:0] id_a;
    logic        iv_a;
    logic        ib_a;
    logic [15:0] od_a;
    logic        ov_a;
    logic        ob_a;
    logic        empty_a;
    logic        err_a;

    logic        rst_s;
    logic [0:0]  id_s;
    logic        iv_s;
    logic        ib_s;
    logic [0:0]  od_s;
    logic        ov_s;
    logic        ob_s;
    logic        empty_s;
    logic        err_s;

    int vectors = 0;
    int miscompares = 0;

    q_relay_pipe #(.DEPTH(4), .WIDTH(16), .SLOTS(3)) dut_a (
        .clock(clock), .reset(rst_a),
        .i_d(id_a), .i_v(iv_a), .i_b(ib_a),
        .o_d(od_a), .o_v(ov_a), .o_b(ob_a),
        .o_empty(empty_a), .o_err(err_a)
    );

    q_relay_pipe #(.DEPTH(1), .WIDTH(1), .SLOTS(3)) dut_s (
        .clock(clock), .reset(rst_s),
        .i_d(id_s), .i_v(iv_s), .i_b(ib_s),
        .o_d(od_s), .o_v(ov_s), .o_b(ob_s),
        .o_empty(empty_s), .o_err(err_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Ramp producer (honours registered i_b) plus in-order consumer on dut_a.
    task automatic stream_a(input int n, input int stall_at, input int stall_len,
                            output int got, output int first, output int last,
                            output int slack, output int rise, output bit ib_any);
        int  sent;
        int  cyc;
        bit  b_reg;
        sent = 0; got = 0; cyc = 0; first = -1; last = -1;
        slack = 0; rise = -1; ib_any = 1'b0;
        b_reg = ib_a;
        while (got < n && cyc < 600) begin
            ob_a = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            if (ov_a) begin
                check("order", {16'h0, od_a}, got);
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                if (ob_a) slack++;
            end
            if (ib_a) ib_any = 1'b1;
            if (ib_a && rise < 0 && cyc >= stall_at) rise = cyc;
            iv_a = (sent < n) && !b_reg;
            id_a = sent[15:0];
            if (iv_a) sent++;
            b_reg = ib_a;
            step();
            cyc++;
        end
        iv_a = 1'b0;
        ob_a = 1'b0;
    endtask

    initial begin
        int  got, first, last, slack, rise;
        bit  ib_any;
        logic q[$];
        int  sent_s, got_s, max_occ;
        bit  b_reg_s;

        rst_a = 1'b1; id_a = '0; iv_a = 1'b0; ob_a = 1'b0;
        rst_s = 1'b1; id_s = '0; iv_s = 1'b0; ob_s = 1'b0;
        step();
        step();
        check("rst_ov", ov_a, 0);
        check("rst_ib", ib_a, 1);
        check("rst_empty", empty_a, 1);
        check("rst_err", err_a, 0);
        rst_a = 1'b0;
        rst_s = 1'b0;
        step();
        check("rel_ib_a", ib_a, 0);
        check("rel_ib_s", ib_s, 0);

        // Single item, latency DEPTH
        repeat (6) step();
        iv_a = 1'b1; id_a = 16'hA5A5;
        step();
        iv_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check("single_ov", ov_a, (k == 4) ? 1 : 0);
            if (k == 4) check("single_od", od_a, 16'hA5A5);
            step();
        end

        // Back-to-back ramp, no stall
        stream_a(100, 10000, 0, got, first, last, slack, rise, ib_any);
        check("ramp_count", got, 100);
        check("ramp_first", first, 4);
        check("ramp_span", last - first, 99);
        check("ramp_ib", ib_any, 0);
        check("ramp_err", err_a, 0);
        check("ramp_empty", empty_a, 1);

        // Ramp with 20-cycle consumer stall
        stream_a(100, 30, 20, got, first, last, slack, rise, ib_any);
        check("stall_count", got, 100);
        check("stall_slack", slack <= 2, 1);
        check("stall_rise_seen", rise > 30, 1);
        check("stall_rise_bound", rise <= 30 + 2 * 4 + 2, 1);
        check("stall_err", err_a, 0);
        check("stall_empty", empty_a, 1);

        // Producer ignores i_b while consumer stalls
        ob_a = 1'b1;
        iv_a = 1'b1;
        for (int k = 0; k < 30; k++) begin
            id_a = k[15:0];
            step();
            if (k == 4) check("ovf_early_err", err_a, 0);
        end
        check("ovf_err", err_a, 1);
        iv_a = 1'b0;
        ob_a = 1'b0;
        repeat (30) step();
        check("ovf_sticky", err_a, 1);
        check("ovf_drained", empty_a, 1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("ovf_clear", err_a, 0);
        step();

        // Reset mid-stream with items in flight
        for (int k = 0; k < 6; k++) begin
            iv_a = 1'b1; id_a = 16'h0100 + k[15:0];
            step();
        end
        check("mid_busy", empty_a, 0);
        rst_a = 1'b1; iv_a = 1'b1; id_a = 16'h1234;
        step();
        rst_a = 1'b0; iv_a = 1'b0;
        check("mid_ov", ov_a, 0);
        check("mid_ib", ib_a, 1);
        check("mid_empty", empty_a, 1);
        check("mid_err", err_a, 0);
        step();
        check("mid_ib_low", ib_a, 0);
        check("mid_quiet0", ov_a, 0);
        step();
        check("mid_quiet1", ov_a, 0);
        iv_a = 1'b1; id_a = 16'hBEEF;
        step();
        iv_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("mid_lat_ov", ov_a, (k == 4) ? 1 : 0);
            if (k == 4) check("mid_lat_od", od_a, 16'hBEEF);
            step();
        end

        // Corner DEPTH=1, WIDTH=1: random traffic against a scoreboard
        sent_s = 0; got_s = 0; max_occ = 0;
        b_reg_s = ib_s;
        for (int c = 0; c < 400; c++) begin
            ob_s = ($urandom_range(0, 2) == 0);
            if (ov_s) begin
                check("s_nonempty", q.size() != 0, 1);
                if (q.size() != 0) check("s_data", od_s, q.pop_front());
                got_s++;
            end
            iv_s = !b_reg_s && ($urandom_range(0, 3) != 0);
            id_s = 1'($urandom_range(0, 1));
            if (iv_s) begin
                q.push_back(id_s[0]);
                sent_s++;
            end
            b_reg_s = ib_s;
            if (sent_s - got_s > max_occ) max_occ = sent_s - got_s;
            step();
        end
        iv_s = 1'b0;
        ob_s = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ov_s) begin
                check("s_nonempty", q.size() != 0, 1);
                if (q.size() != 0) check("s_data", od_s, q.pop_front());
                got_s++;
            end
            step();
        end
        check("s_all_out", q.size(), 0);
        check("s_count", got_s, sent_s);
        check("s_occ", max_occ <= 3, 1);
        check("s_err", err_s, 0);
        check("s_empty", empty_s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
